// File: rtl/vector_mem_sequencer_if.sv
// Bundle of the vector-request, scalar-stage and data-memory signals around vector_mem_sequencer.
`default_nettype none

interface vector_mem_sequencer_if #(
  parameter int N = 32,
  parameter int V = 256
);
  logic           start;
  logic           write;
  logic [N-1:0]   base_addr;
  logic [V-1:0]   wdata_v;
  logic           busy;
  logic           done;
  logic [V-1:0]   rdata_v;

  logic [N-1:0]   s_addr;
  logic [N-1:0]   s_wdata;
  logic           s_rden;
  logic           s_wren;
  logic [N/8-1:0] s_byteena;
  logic [N-1:0]   s_rdata;

  logic [N-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic           mem_rden;
  logic           mem_wren;
  logic [N/8-1:0] mem_byteena;
  logic [N-1:0]   mem_rdata;

  modport slave (
    input  start, write, base_addr, wdata_v,
    output busy, done, rdata_v,
    input  s_addr, s_wdata, s_rden, s_wren, s_byteena,
    output s_rdata,
    output mem_addr, mem_wdata, mem_rden, mem_wren, mem_byteena,
    input  mem_rdata
  );

  modport master (
    output start, write, base_addr, wdata_v,
    input  busy, done, rdata_v,
    output s_addr, s_wdata, s_rden, s_wren, s_byteena,
    input  s_rdata,
    input  mem_addr, mem_wdata, mem_rden, mem_wren, mem_byteena,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/vector_mem_sequencer.sv
// Shares one N-bit data-memory port between scalar accesses and V-bit vector loads/stores,
// splitting each vector access into V/N word transactions.
`default_nettype none

module vector_mem_sequencer #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  wire logic              clk,
  input  wire logic              rst,
  vector_mem_sequencer_if.slave  bus
);

  localparam int L  = V / N;
  localparam int IW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STORE  = 3'd1,
    LOAD   = 3'd2,
    LDRAIN = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [N-1:0]    eff_addr;
  logic [V-1:0]    store_buf;
  logic [V-1:0]    rdata_r;
  logic            pend;
  logic [IW-1:0]   pend_idx;

  logic            last_lane;
  logic [N-1:0]    lane_addr;
  logic [N-1:0]    lane_wdata;

  logic [N-1:0]    mem_addr_c;
  logic [N-1:0]    mem_wdata_c;
  logic            mem_rden_c;
  logic            mem_wren_c;
  logic [N/8-1:0]  mem_byteena_c;

  assign last_lane  = (idx == IW'(L - 1));
  assign lane_addr  = eff_addr + (N'(idx) << 2);
  assign lane_wdata = store_buf[idx*N +: N];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      eff_addr  <= '0;
      store_buf <= '0;
      rdata_r   <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
    end else begin
      state    <= state_nxt;
      pend     <= (state == LOAD);
      pend_idx <= idx;
      if (state == IDLE && bus.start) begin
        eff_addr  <= bus.base_addr & ~N'(3);
        store_buf <= bus.wdata_v;
        idx       <= '0;
      end else if (state == STORE || state == LOAD) begin
        idx <= last_lane ? '0 : idx + 1'b1;
      end
      // Synchronous-read data for the lane requested on the previous edge
      if (pend) begin
        rdata_r[pend_idx*N +: N] <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_addr_c    = '0;
    mem_wdata_c   = '0;
    mem_rden_c    = 1'b0;
    mem_wren_c    = 1'b0;
    mem_byteena_c = '0;
    case (state)
      IDLE: begin
        mem_addr_c    = bus.s_addr;
        mem_wdata_c   = bus.s_wdata;
        mem_rden_c    = bus.s_rden;
        mem_wren_c    = bus.s_wren;
        mem_byteena_c = bus.s_byteena;
        if (bus.start) begin
          state_nxt = bus.write ? STORE : LOAD;
        end
      end
      STORE: begin
        mem_addr_c    = lane_addr;
        mem_wdata_c   = lane_wdata;
        mem_wren_c    = 1'b1;
        mem_byteena_c = '1;
        if (last_lane) begin
          state_nxt = DONE;
        end
      end
      LOAD: begin
        mem_addr_c    = lane_addr;
        mem_rden_c    = 1'b1;
        mem_byteena_c = '1;
        if (last_lane) begin
          state_nxt = LDRAIN;
        end
      end
      LDRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        mem_addr_c    = bus.s_addr;
        mem_wdata_c   = bus.s_wdata;
        mem_rden_c    = bus.s_rden;
        mem_wren_c    = bus.s_wren;
        mem_byteena_c = bus.s_byteena;
        state_nxt     = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state == STORE) || (state == LOAD) || (state == LDRAIN);
  assign bus.done        = (state == DONE);
  assign bus.rdata_v     = rdata_r;
  assign bus.s_rdata     = bus.mem_rdata;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;
  assign bus.mem_rden    = mem_rden_c;
  assign bus.mem_wren    = mem_wren_c;
  assign bus.mem_byteena = mem_byteena_c;

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_sequencer.sv
// Directed self-checking bench for vector_mem_sequencer with a synchronous-read memory model.
`default_nettype none

module tb_vector_mem_sequencer;

  localparam int N = 32;
  localparam int V = 256;
  localparam int L = V / N;
  localparam logic [31:0] XOR_PAT = 32'hA5A5A5A5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vector_mem_sequencer_if #(.N(N), .V(V)) bus ();

  vector_mem_sequencer #(.N(N), .V(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read returning address ^ pattern
  always @(posedge clk) begin
    if (bus.mem_rden) bus.mem_rdata <= bus.mem_addr ^ XOR_PAT;
  end

  always @(negedge clk) begin
    if (rst && bus.busy && (bus.s_rden || bus.s_wren)) begin
      errors++;
      $display("FAIL scalar_while_busy: s_rden=%0b s_wren=%0b, required both 0", bus.s_rden, bus.s_wren);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.write     = 1'b0;
    bus.base_addr = '0;
    bus.wdata_v   = '0;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_rden    = 1'b0;
    bus.s_wren    = 1'b0;
    bus.s_byteena = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.rdata_v !== '0) begin
      errors++; $display("FAIL reset_rdata: rdata_v=%h, required 0", bus.rdata_v);
    end
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.mem_rden !== 1'b0 || bus.mem_byteena !== 4'b0) begin
      errors++; $display("FAIL reset_mem: wren=%b rden=%b be=%b, required 0 0 0",
                         bus.mem_wren, bus.mem_rden, bus.mem_byteena);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_scalar();
    bus.s_addr    = 32'h40;
    bus.s_wren    = 1'b1;
    bus.s_wdata   = 32'hDEADBEEF;
    bus.s_byteena = 4'b0011;
    #1;
    checks++;
    if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_wren !== 1'b1 ||
        bus.mem_rden !== 1'b0 || bus.mem_byteena !== 4'b0011 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL scalar_pass: addr=%h wdata=%h wren=%b rden=%b be=%b busy=%b, required 40 deadbeef 1 0 0011 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_wren, bus.mem_rden, bus.mem_byteena, bus.busy);
    end
    tick();
    idle_inputs();
    #1;
  endtask

  task automatic test_store();
    bus.start     = 1'b1;
    bus.write     = 1'b1;
    bus.base_addr = 32'h100;
    for (int k = 0; k < L; k++) bus.wdata_v[k*N +: N] = 32'h11111111 * k;
    for (int c = 1; c <= L; c++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.mem_wren !== 1'b1 || bus.mem_rden !== 1'b0 ||
          bus.mem_byteena !== 4'hF || bus.mem_addr !== 32'h100 + 32'(4 * (c - 1)) ||
          bus.mem_wdata !== 32'h11111111 * (c - 1)) begin
        errors++;
        $display("FAIL store_cycle%0d: busy=%b done=%b wren=%b be=%b addr=%h wdata=%h, required 1 0 1 f %h %h",
                 c, bus.busy, bus.done, bus.mem_wren, bus.mem_byteena, bus.mem_addr, bus.mem_wdata,
                 32'h100 + 32'(4 * (c - 1)), 32'h11111111 * (c - 1));
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_wren !== 1'b0) begin
      errors++; $display("FAIL store_done: done=%b busy=%b wren=%b, required 1 0 0", bus.done, bus.busy, bus.mem_wren);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL store_after: done=%b busy=%b, required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic run_load(input logic [31:0] base, input logic [31:0] eff);
    logic [31:0] exp_addr;
    bus.start     = 1'b1;
    bus.write     = 1'b0;
    bus.base_addr = base;
    for (int c = 1; c <= L; c++) begin
      tick();
      exp_addr = eff + 32'(4 * (c - 1));
      checks++;
      if (bus.busy !== 1'b1 || bus.mem_rden !== 1'b1 || bus.mem_wren !== 1'b0 ||
          bus.mem_byteena !== 4'hF || bus.mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL load_cycle%0d: busy=%b rden=%b wren=%b be=%b addr=%h, required 1 1 0 f %h",
                 c, bus.busy, bus.mem_rden, bus.mem_wren, bus.mem_byteena, bus.mem_addr, exp_addr);
      end
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.mem_rden !== 1'b0 || bus.mem_byteena !== 4'h0) begin
      errors++; $display("FAIL load_drain: busy=%b done=%b rden=%b be=%b, required 1 0 0 0",
                         bus.busy, bus.done, bus.mem_rden, bus.mem_byteena);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL load_done: done=%b busy=%b, required 1 0", bus.done, bus.busy);
    end
    for (int k = 0; k < L; k++) begin
      exp_addr = (eff + 32'(4 * k)) ^ XOR_PAT;
      checks++;
      if (bus.rdata_v[k*N +: N] !== exp_addr) begin
        errors++; $display("FAIL load_lane%0d: got %h, required %h", k, bus.rdata_v[k*N +: N], exp_addr);
      end
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.rdata_v[0 +: N] !== (eff ^ XOR_PAT) || bus.done !== 1'b0) begin
      errors++; $display("FAIL load_hold: lane0=%h done=%b, required %h 0", bus.rdata_v[0 +: N], bus.done, eff ^ XOR_PAT);
    end
  endtask

  task automatic test_load();
    run_load(32'h203, 32'h200);
  endtask

  task automatic test_wrap();
    run_load(32'hFFFFFFF8, 32'hFFFFFFF8);
  endtask

  task automatic test_back_to_back();
    bus.start     = 1'b1;
    bus.write     = 1'b1;
    bus.base_addr = 32'h300;
    bus.wdata_v   = {8{32'hCAFEF00D}};
    for (int c = 1; c <= L; c++) tick();
    tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: done=%b, required 1", bus.done);
    end
    bus.base_addr = 32'h400;
    bus.wdata_v   = {8{32'h0BADF00D}};
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_wren !== 1'b0) begin
      errors++; $display("FAIL b2b_no_reaccept: busy=%b done=%b wren=%b, required 0 0 0",
                         bus.busy, bus.done, bus.mem_wren);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_wren !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_wdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL b2b_second: busy=%b wren=%b addr=%h wdata=%h, required 1 1 400 0badf00d",
                         bus.busy, bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    for (int c = 2; c <= L; c++) tick();
    tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_done: done=%b, required 1", bus.done);
    end
    bus.start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    bus.start     = 1'b1;
    bus.write     = 1'b0;
    bus.base_addr = 32'h500;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_rden !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flags: busy=%b done=%b rden=%b, required 0 0 0",
                         bus.busy, bus.done, bus.mem_rden);
    end
    checks++;
    if (bus.rdata_v !== '0) begin
      errors++; $display("FAIL rst_mid_rdata: rdata_v=%h, required 0", bus.rdata_v);
    end
    #1;
    rst = 1'b1;
    bus.s_addr    = 32'h80;
    bus.s_rden    = 1'b1;
    bus.s_byteena = 4'hF;
    #1;
    checks++;
    if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 32'h80 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_scalar_req: rden=%b addr=%h busy=%b, required 1 80 0",
                         bus.mem_rden, bus.mem_addr, bus.busy);
    end
    tick();
    bus.s_rden = 1'b0;
    #1;
    checks++;
    if (bus.s_rdata !== (32'h80 ^ XOR_PAT) || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rst_scalar_data: s_rdata=%h busy=%b, required %h 0",
                         bus.s_rdata, bus.busy, 32'h80 ^ XOR_PAT);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.mem_rdata = '0;
    test_reset();
    test_scalar();
    test_store();
    test_load();
    test_wrap();
    test_back_to_back();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
